pipelined_ones_counter: RTL and testbench

Parametrised, pipelined successor to the fixed seven-input ones counter. Counts the ones in a WIDTH-bit word each cycle using 7-input lane counters followed by a registered lane-sum stage. Also keeps a saturating running total across multi-word frames delimited by in_last. Sits between a streaming data source and a statistics/threshold block, using valid/ready handshakes on both sides.

---
 rtl/pipelined_ones_counter_pkg.sv | 22 ++
 rtl/pipelined_ones_counter_if.sv | 39 +++
 rtl/seven_bit_lane_counter.sv | 18 +
 rtl/pipelined_ones_counter.sv | 118 +++++++++++
 tb/tb_pipelined_ones_counter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipelined_ones_counter_pkg.sv
// Shared types and sizing helpers for the pipelined ones counter.
package ones_counter_pkg;

  localparam int LANE_W  = 7;
  localparam int LANE_CW = 3;

  typedef logic [LANE_CW-1:0] lane_cnt_t;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_OPEN = 1'b1
  } frame_state_t;

  function automatic int lanes_f(input int width);
    return (width + LANE_W - 1) / LANE_W;
  endfunction

  function automatic int cw_f(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/pipelined_ones_counter_if.sv
// Stream bundle for the ones counter: word in, count/total out.
// count_zeros exists only when ONES_COUNTER_ZERO_MODE_EN is defined.
interface pipelined_ones_counter_if #(
  parameter int WIDTH = 21,
  parameter int ACC_W = 16
);
  localparam int CW = ones_counter_pkg::cw_f(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
`ifdef ONES_COUNTER_ZERO_MODE_EN
  logic             count_zeros;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic [ACC_W-1:0] out_total;
  logic             out_last;
  logic             out_sat;

  modport master (
`ifdef ONES_COUNTER_ZERO_MODE_EN
    output count_zeros,
`endif
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

  modport slave (
`ifdef ONES_COUNTER_ZERO_MODE_EN
    input  count_zeros,
`endif
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

endinterface

// File: rtl/seven_bit_lane_counter.sv
// Purpose: population count of one 7-bit lane.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module seven_bit_lane_counter
  import ones_counter_pkg::*;
(
  input  logic [LANE_W-1:0] bits,
  output lane_cnt_t         count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANE_W; i++) begin
      count = count + lane_cnt_t'(bits[i]);
    end
  end

endmodule

// File: rtl/pipelined_ones_counter.sv
// Purpose: per-word ones count plus saturating frame total (zero counting via ONES_COUNTER_ZERO_MODE_EN).
// Latency: 2 cycles, one word per cycle.
// Backpressure: out_valid && !out_ready freezes both stages and drops in_ready.
module pipelined_ones_counter
  import ones_counter_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int ACC_W = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_ones_counter_if.slave bus
);

  localparam int LANES = lanes_f(WIDTH);
  localparam int CW    = cw_f(WIDTH);
  localparam int PAD_W = LANES * LANE_W;

  logic             stall;
  logic [WIDTH-1:0] word;
  logic [PAD_W-1:0] padded;
  lane_cnt_t        lane_cnt [LANES];

  logic             s1_valid;
  logic             s1_last;
  lane_cnt_t        s1_lane  [LANES];

  logic [CW-1:0]    lane_sum;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] total_nxt;
  logic             sat_nxt;
  logic [ACC_W-1:0] acc;

  frame_state_t     frame_q;
  frame_state_t     frame_nxt;
  logic             frame_open;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Inversion happens before padding so pad bits never count as zeros.
`ifdef ONES_COUNTER_ZERO_MODE_EN
  assign word = bus.count_zeros ? ~bus.in_data : bus.in_data;
`else
  assign word = bus.in_data;
`endif
  assign padded = PAD_W'(word);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    seven_bit_lane_counter u_lane (
      .bits  (padded[g*LANE_W +: LANE_W]),
      .count (lane_cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_lane[i] <= '0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      s1_last  <= bus.in_last;
      s1_lane  <= lane_cnt;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + CW'(s1_lane[i]);
    end
  end

  // The extra sum bit is the overflow flag; ACC_W >= CW keeps it exact.
  assign base      = frame_open ? acc : '0;
  assign sum       = {1'b0, base} + (ACC_W+1)'(lane_sum);
  assign total_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign sat_nxt   = sum[ACC_W] || (frame_open && bus.out_sat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_count <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sat   <= 1'b0;
      acc           <= '0;
    end else if (!stall) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_count <= lane_sum;
        bus.out_last  <= s1_last;
        bus.out_sat   <= sat_nxt;
        acc           <= total_nxt;
      end
    end
  end

  assign bus.out_total = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) frame_q <= FRAME_IDLE;
    else        frame_q <= frame_nxt;
  end

  always_comb begin
    frame_nxt = frame_q;
    if (!stall && s1_valid) begin
      frame_nxt = s1_last ? FRAME_IDLE : FRAME_OPEN;
    end
  end

  always_comb begin
    frame_open = (frame_q == FRAME_OPEN);
  end

endmodule

// File: tb/tb_pipelined_ones_counter.sv
// Directed bench: dut_a (21/16) and dut_b (21/5) share stimulus, dut_c (10/16) covers padding.
// Zero counting is exercised when ONES_COUNTER_ZERO_MODE_EN is defined.
module tb_pipelined_ones_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_last, out_ready;
  logic [20:0] din;
  logic        c_valid, c_last, c_ready;
  logic [9:0]  c_data;
`ifdef ONES_COUNTER_ZERO_MODE_EN
  logic        c_zeros;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_ones_counter_if #(.WIDTH(21), .ACC_W(16)) ifa ();
  pipelined_ones_counter_if #(.WIDTH(21), .ACC_W(5))  ifb ();
  pipelined_ones_counter_if #(.WIDTH(10), .ACC_W(16)) ifc ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = din;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = din;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid  = c_valid;
  assign ifc.in_data   = c_data;
  assign ifc.in_last   = c_last;
  assign ifc.out_ready = c_ready;
`ifdef ONES_COUNTER_ZERO_MODE_EN
  assign ifa.count_zeros = 1'b0;
  assign ifb.count_zeros = 1'b0;
  assign ifc.count_zeros = c_zeros;
`endif

  pipelined_ones_counter #(.WIDTH(21), .ACC_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pipelined_ones_counter #(.WIDTH(21), .ACC_W(5))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  pipelined_ones_counter #(.WIDTH(10), .ACC_W(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int cnt, input int tot, input bit last);
    chk({tag, "_a_valid"}, 32'(ifa.out_valid), 1);
    chk({tag, "_a_count"}, 32'(ifa.out_count), cnt);
    chk({tag, "_a_total"}, 32'(ifa.out_total), tot);
    chk({tag, "_a_last"},  32'(ifa.out_last),  32'(last));
  endtask

  task automatic chk_b(input string tag, input int tot, input bit sat);
    chk({tag, "_b_total"}, 32'(ifb.out_total), tot);
    chk({tag, "_b_sat"},   32'(ifb.out_sat),   32'(sat));
  endtask

  int  sent, got;
  bit  took;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; din = 21'h1FFFFF; in_last = 1'b1; out_ready = 1'b1;
    c_valid = 1'b0; c_data = '0; c_last = 1'b0; c_ready = 1'b1;
`ifdef ONES_COUNTER_ZERO_MODE_EN
    c_zeros = 1'b0;
`endif

    // Reset held with a valid word presented
    tick; tick;
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_out_total", 32'(ifa.out_total), 0);
    chk("rst_out_sat",   32'(ifa.out_sat),   0);
    chk("rst_in_ready",  32'(ifa.in_ready),  1);
    chk("rst_c_valid",   32'(ifc.out_valid), 0);

    rst_n = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk_a("first", 21, 21, 1'b1);
    chk_b("first", 21, 1'b0);
    tick;
    chk("first_drain", 32'(ifa.out_valid), 0);

    // Frame accumulation then a back-to-back one-word frame
    in_valid = 1'b1; din = 21'h000007; in_last = 1'b0; tick;
    din = 21'h0000FF; tick;
    chk_a("acc0", 3, 3, 1'b0);
    din = 21'h100000; in_last = 1'b1; tick;
    chk_a("acc1", 8, 11, 1'b0);
    din = 21'h000003; in_last = 1'b1; tick;
    chk_a("acc2", 1, 12, 1'b1);
    chk_b("acc2", 12, 1'b0);
    in_valid = 1'b0; tick;
    chk_a("acc3", 2, 2, 1'b1);
    tick;
    chk("acc_drain", 32'(ifa.out_valid), 0);

    // Backpressure: out_ready low for cycles 3..6 while the source keeps pushing
    sent = 0; got = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 5);
      din       = 21'h000001;
      in_last   = (sent == 4);
      #1;
      took = in_valid && ifa.in_ready;
      if (!out_ready && ifa.out_valid)
        chk("bp_in_ready_low", 32'(ifa.in_ready), 0);
      if (out_ready && ifa.out_valid) begin
        got++;
        chk("bp_count", 32'(ifa.out_count), 1);
        chk("bp_total", 32'(ifa.out_total), 32'(got));
        chk("bp_last",  32'(ifa.out_last),  32'(got == 5));
      end
      tick;
      if (took) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 5);
    chk("bp_got",  32'(got),  5);

    // Saturation on dut_b, sticky through an all-zero word, cleared by next frame
    in_valid = 1'b1; din = 21'h1FFFFF; in_last = 1'b0; tick;
    tick;
    chk_a("sat0", 21, 21, 1'b0);
    chk_b("sat0", 21, 1'b0);
    din = 21'h000000; in_last = 1'b1; tick;
    chk_a("sat1", 21, 42, 1'b0);
    chk_b("sat1", 31, 1'b1);
    din = 21'h000001; in_last = 1'b1; tick;
    chk_a("sat2", 0, 42, 1'b1);
    chk_b("sat2", 31, 1'b1);
    in_valid = 1'b0; tick;
    chk_a("sat3", 1, 1, 1'b1);
    chk_b("sat3", 1, 1'b0);
    tick;

    // Padding on the 10-bit instance
    c_valid = 1'b1; c_data = 10'h3FF; c_last = 1'b1; tick;
    c_valid = 1'b0; tick;
    chk("pad_count", 32'(ifc.out_count), 10);
    chk("pad_total", 32'(ifc.out_total), 10);

    // Open a frame, reset mid-frame, then a fresh one-word frame
    c_valid = 1'b1; c_data = 10'h0F0; c_last = 1'b0; tick;
    c_valid = 1'b0; tick;
    chk("open_total", 32'(ifc.out_total), 4);
    rst_n = 1'b0; tick;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(ifc.out_valid), 0);
    chk("midrst_total", 32'(ifc.out_total), 0);
    c_valid = 1'b1; c_data = 10'h001; c_last = 1'b1; tick;
    c_valid = 1'b0; tick;
    chk("midrst_new_total", 32'(ifc.out_total), 1);
    tick;

`ifdef ONES_COUNTER_ZERO_MODE_EN
    c_valid = 1'b1; c_data = 10'h00F; c_last = 1'b1; c_zeros = 1'b1; tick;
    c_zeros = 1'b0; tick;
    chk("zero_count", 32'(ifc.out_count), 6);
    chk("zero_total", 32'(ifc.out_total), 6);
    c_valid = 1'b0; tick;
    chk("ones_count", 32'(ifc.out_count), 4);
    chk("ones_total", 32'(ifc.out_total), 4);
    tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
